// File: rtl/d_kes_elp_deg_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : d_kes_elp_deg_chk_pkg
//  Brief   : Shared KES parameters, degree width and degree-check FSM states
//  Revision: 1.0  initial release
// ============================================================================
package d_kes_elp_deg_chk_pkg;

    localparam int D_KES_GF_ORDER = 12;
    localparam int D_KES_ECC_T    = 14;
    localparam int D_KES_DEG_W    = 5;

    // Degree-check sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_CAPT = 3'd2,
        ST_CALC = 3'd3,
        ST_HOLD = 3'd4
    } deg_state_t;

endpackage : d_kes_elp_deg_chk_pkg
`default_nettype wire

// File: rtl/d_kes_elp_deg_chk_if.sv
`default_nettype none
// ============================================================================
//  Module  : d_kes_elp_deg_chk_if
//  Brief   : ELP degree result handshake towards the Chien-search launcher
//  Revision: 1.0  initial release
// ============================================================================
interface d_kes_elp_deg_chk_if #(
    parameter int DEG_W = 5
);
    logic             deg_valid;
    logic             deg_ready;
    logic [DEG_W-1:0] elp_degree;
    logic             no_error;
    logic             uncorrectable;

    // Degree-check block drives the result
    modport master (
        output deg_valid,
        output elp_degree,
        output no_error,
        output uncorrectable,
        input  deg_ready
    );

    // Chien-search launcher consumes the result
    modport slave (
        input  deg_valid,
        input  elp_degree,
        input  no_error,
        input  uncorrectable,
        output deg_ready
    );
endinterface : d_kes_elp_deg_chk_if
`default_nettype wire

// File: rtl/d_kes_elp_deg_chk_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module  : d_kes_deg_prio_enc
//  Brief   : Highest-set-bit encoder with any-set flag
//  Revision: 1.0  initial release
// ============================================================================
module d_kes_deg_prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  wire logic [WIDTH-1:0] vec,
    output logic      [IDX_W-1:0] idx,
    output logic                  any_set
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        idx     = '0;
        any_set = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (vec[k]) begin
                idx     = IDX_W'(k);
                any_set = 1'b1;
            end
        end
    end

endmodule : d_kes_deg_prio_enc
`default_nettype wire

// File: rtl/d_kes_elp_deg_chk.sv
`default_nettype none
// ============================================================================
//  Module  : d_kes_elp_deg_chk
//  Brief   : Counts KES iterations, latches PE degree-check bits, computes the
//            ELP degree and error class, and hands it off over valid/ready
//  Revision: 1.0  initial release
// ============================================================================
module d_kes_elp_deg_chk
    import d_kes_elp_deg_chk_pkg::*;
#(
    parameter int ECC_T = D_KES_ECC_T,
    parameter int DEG_W = D_KES_DEG_W
) (
    input  wire logic             i_clk,
    input  wire logic             i_nRESET_KES,
    input  wire logic             i_stop_dec,
    input  wire logic             i_EXECUTE_PE_ELU,
    input  wire logic [ECC_T:0]   i_v_deg_chk_bits,
    input  wire logic             i_v_eMAX_deg_chk,
    output logic                  o_busy,
    output logic                  o_overrun,
    d_kes_elp_deg_chk_if.master   deg_if
);

    localparam logic [DEG_W-1:0] C_LAST_ITER = DEG_W'(ECC_T);
    localparam logic [DEG_W-1:0] C_ONE       = DEG_W'(1);
    // The first pulse of a run lands in RUN, or directly in CAPT when one
    // iteration is the whole run.
    localparam deg_state_t       C_FIRST_ST  = (ECC_T == 1) ? ST_CAPT : ST_RUN;

    deg_state_t         r_state;
    deg_state_t         w_state_nxt;
    logic [DEG_W-1:0]   r_iter_cnt;
    logic [ECC_T+1:0]   r_capt_bits;
    logic [DEG_W-1:0]   r_degree;
    logic               r_no_error;
    logic               r_uncorr;
    logic               r_valid;
    logic               r_busy;
    logic               r_overrun;
    logic               w_accept;
    logic               w_late_pulse;
    logic [DEG_W-1:0]   w_enc_idx;
    logic               w_enc_any;

    assign w_accept     = (r_state == ST_HOLD) && r_valid && deg_if.deg_ready;
    // A pulse in the accept cycle starts the next run, so it is not an overrun
    assign w_late_pulse = i_EXECUTE_PE_ELU &&
                          ((r_state == ST_CAPT) || (r_state == ST_CALC) ||
                           ((r_state == ST_HOLD) && !w_accept));

    d_kes_deg_prio_enc #(
        .WIDTH (ECC_T + 2),
        .IDX_W (DEG_W)
    ) u_prio_enc (
        .vec     (r_capt_bits),
        .idx     (w_enc_idx),
        .any_set (w_enc_any)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_nRESET_KES) begin
        if (!i_nRESET_KES) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (i_stop_dec) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_EXECUTE_PE_ELU) w_state_nxt = C_FIRST_ST;
                ST_RUN:  if (i_EXECUTE_PE_ELU && (r_iter_cnt == C_LAST_ITER - C_ONE))
                             w_state_nxt = ST_CAPT;
                ST_CAPT: w_state_nxt = ST_CALC;
                ST_CALC: w_state_nxt = ST_HOLD;
                ST_HOLD: if (w_accept)
                             w_state_nxt = i_EXECUTE_PE_ELU ? C_FIRST_ST : ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Iteration counter
    always_ff @(posedge i_clk or negedge i_nRESET_KES) begin
        if (!i_nRESET_KES) begin
            r_iter_cnt <= '0;
        end else if (i_stop_dec) begin
            r_iter_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_EXECUTE_PE_ELU) r_iter_cnt <= C_ONE;
                ST_RUN:  if (i_EXECUTE_PE_ELU) r_iter_cnt <= r_iter_cnt + C_ONE;
                ST_HOLD: if (w_accept) r_iter_cnt <= i_EXECUTE_PE_ELU ? C_ONE : '0;
                default: r_iter_cnt <= r_iter_cnt;
            endcase
        end
    end

    // Capture PE bits, compute result, hold until accepted
    always_ff @(posedge i_clk or negedge i_nRESET_KES) begin
        if (!i_nRESET_KES) begin
            r_capt_bits <= '0;
            r_degree    <= '0;
            r_no_error  <= 1'b0;
            r_uncorr    <= 1'b0;
            r_valid     <= 1'b0;
        end else if (i_stop_dec) begin
            r_capt_bits <= '0;
            r_degree    <= '0;
            r_no_error  <= 1'b0;
            r_uncorr    <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (r_state == ST_CAPT) begin
                r_capt_bits <= {i_v_eMAX_deg_chk, i_v_deg_chk_bits};
            end
            if (r_state == ST_CALC) begin
                // eMAX sits at the top of the encoder, so it dominates the index
                r_degree   <= w_enc_idx;
                r_uncorr   <= r_capt_bits[ECC_T+1] || !w_enc_any;
                r_no_error <= !r_capt_bits[ECC_T+1] && w_enc_any && (w_enc_idx == '0);
                r_valid    <= 1'b1;
            end
            if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Registered busy and sticky overrun flags
    always_ff @(posedge i_clk or negedge i_nRESET_KES) begin
        if (!i_nRESET_KES) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_stop_dec) begin
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_late_pulse) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_busy               = r_busy;
    assign o_overrun            = r_overrun;
    assign deg_if.deg_valid     = r_valid;
    assign deg_if.elp_degree    = r_degree;
    assign deg_if.no_error      = r_no_error;
    assign deg_if.uncorrectable = r_uncorr;

endmodule : d_kes_elp_deg_chk
`default_nettype wire

// File: tb/tb_d_kes_elp_deg_chk.sv
`default_nettype none
// ============================================================================
//  Module  : tb_d_kes_elp_deg_chk
//  Brief   : Self-checking bench for the ELP degree check block
//  Revision: 1.0  initial release
// ============================================================================
module tb_d_kes_elp_deg_chk;

    localparam int ECC_T = 14;
    localparam int DEG_W = 5;

    logic              i_clk = 1'b0;
    logic              i_nRESET_KES = 1'b0;
    logic              i_stop_dec = 1'b0;
    logic              i_EXECUTE_PE_ELU = 1'b0;
    logic [ECC_T:0]    i_v_deg_chk_bits = '0;
    logic              i_v_eMAX_deg_chk = 1'b0;
    logic              o_busy;
    logic              o_overrun;

    int checks = 0;
    int errors = 0;

    // Expected {degree, no_error, uncorrectable}
    logic [DEG_W+1:0] sb[$];

    d_kes_elp_deg_chk_if #(.DEG_W(DEG_W)) deg_if ();

    d_kes_elp_deg_chk #(
        .ECC_T (ECC_T),
        .DEG_W (DEG_W)
    ) dut (
        .i_clk            (i_clk),
        .i_nRESET_KES     (i_nRESET_KES),
        .i_stop_dec       (i_stop_dec),
        .i_EXECUTE_PE_ELU (i_EXECUTE_PE_ELU),
        .i_v_deg_chk_bits (i_v_deg_chk_bits),
        .i_v_eMAX_deg_chk (i_v_eMAX_deg_chk),
        .o_busy           (o_busy),
        .o_overrun        (o_overrun),
        .deg_if           (deg_if)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [DEG_W+1:0] model(input logic [ECC_T:0] bits, input logic emax);
        logic [DEG_W-1:0] d;
        d = '0;
        if (emax) return {DEG_W'(ECC_T + 1), 1'b0, 1'b1};
        if (bits == '0) return {DEG_W'(0), 1'b0, 1'b1};
        for (int k = 0; k <= ECC_T; k++) if (bits[k]) d = DEG_W'(k);
        return {d, (d == '0), 1'b0};
    endfunction

    function automatic logic [DEG_W+1:0] got();
        return {deg_if.elp_degree, deg_if.no_error, deg_if.uncorrectable};
    endfunction

    // Pulses three cycles apart; returns at the falling edge after the last sampled pulse
    task automatic do_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (2) @(negedge i_clk);
            @(negedge i_clk) i_EXECUTE_PE_ELU = 1'b1;
            @(negedge i_clk) i_EXECUTE_PE_ELU = 1'b0;
        end
    endtask

    // Bounded wait for valid; cyc is falling edges waited (99 on timeout)
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (deg_if.deg_valid !== 1'b1 && cyc < 8) begin
            @(negedge i_clk);
            cyc++;
        end
        if (deg_if.deg_valid !== 1'b1) cyc = 99;
    endtask

    task automatic start_run(input logic [ECC_T:0] bits, input logic emax);
        i_v_deg_chk_bits = bits;
        i_v_eMAX_deg_chk = emax;
        sb.push_back(model(bits, emax));
    endtask

    task automatic accept();
        @(negedge i_clk) deg_if.deg_ready = 1'b1;
        @(negedge i_clk) deg_if.deg_ready = 1'b0;
    endtask

    task automatic test_reset();
        deg_if.deg_ready = 1'b0;
        i_nRESET_KES = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_overrun, deg_if.deg_valid, got()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {o_busy, o_overrun, deg_if.deg_valid, got()});
        end
        i_nRESET_KES = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || deg_if.deg_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b expected 0 0", o_busy, deg_if.deg_valid);
        end
    endtask

    task automatic test_basic();
        logic [DEG_W+1:0] e;
        int cyc;
        start_run(15'h000F, 1'b0);
        do_pulses(13);
        checks++;
        if (o_busy !== 1'b1 || deg_if.deg_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_13: busy=%b valid=%b expected 1 0", o_busy, deg_if.deg_valid);
        end
        do_pulses(1);
        wait_valid(cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL latency: got %0d edges expected 2", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (got() !== e) begin
            errors++;
            $display("FAIL basic_result: got %b expected %b", got(), e);
        end
        accept();
        checks++;
        if (o_busy !== 1'b0 || deg_if.deg_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: busy=%b valid=%b expected 0 0", o_busy, deg_if.deg_valid);
        end
    endtask

    task automatic test_patterns();
        logic [ECC_T:0]   pat_b [3] = '{15'h0001, 15'h0000, 15'h7FFF};
        logic             pat_e [3] = '{1'b0, 1'b0, 1'b1};
        logic [DEG_W+1:0] e;
        int cyc;
        for (int p = 0; p < 3; p++) begin
            start_run(pat_b[p], pat_e[p]);
            do_pulses(ECC_T);
            wait_valid(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc === 99 || got() !== e) begin
                errors++;
                $display("FAIL pattern_%0d: got %b expected %b (wait %0d)", p, got(), e, cyc);
            end
            checks++;
            if (deg_if.no_error && deg_if.uncorrectable) begin
                errors++;
                $display("FAIL pattern_%0d_exclusive: no_error=1 uncorrectable=1 expected not both", p);
            end
            accept();
        end
        i_v_eMAX_deg_chk = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DEG_W+1:0] e;
        int cyc;
        start_run(15'h0100, 1'b0);
        do_pulses(ECC_T);
        wait_valid(cyc);
        e = sb.pop_front();
        // Changing inputs while held must not disturb the result
        i_v_deg_chk_bits = 15'h0020;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            checks++;
            if (deg_if.deg_valid !== 1'b1 || got() !== e) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b got %b expected 1 %b", i, deg_if.deg_valid, got(), e);
            end
        end
        sb.push_back(model(15'h0020, 1'b0));
        @(negedge i_clk);
        deg_if.deg_ready = 1'b1;
        i_EXECUTE_PE_ELU = 1'b1;
        @(negedge i_clk);
        deg_if.deg_ready = 1'b0;
        i_EXECUTE_PE_ELU = 1'b0;
        checks++;
        if (deg_if.deg_valid !== 1'b0 || o_busy !== 1'b1 || o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL accept_start: valid=%b busy=%b overrun=%b expected 0 1 0",
                     deg_if.deg_valid, o_busy, o_overrun);
        end
        do_pulses(ECC_T - 1);
        wait_valid(cyc);
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL b2b_latency: got %0d edges expected 2", cyc);
        end
        e = sb.pop_front();
        checks++;
        if (got() !== e) begin
            errors++;
            $display("FAIL b2b_result: got %b expected %b", got(), e);
        end
        accept();
    endtask

    task automatic test_overrun_stop();
        logic [DEG_W+1:0] e;
        int cyc;
        start_run(15'h0003, 1'b0);
        do_pulses(ECC_T);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b expected 0", o_overrun);
        end
        @(negedge i_clk) i_EXECUTE_PE_ELU = 1'b1;
        @(negedge i_clk) i_EXECUTE_PE_ELU = 1'b0;
        checks++;
        if (o_overrun !== 1'b1 || deg_if.deg_valid !== 1'b1 || got() !== e) begin
            errors++;
            $display("FAIL overrun_hold: overrun=%b valid=%b got %b expected 1 1 %b",
                     o_overrun, deg_if.deg_valid, got(), e);
        end
        @(negedge i_clk);
        i_stop_dec = 1'b1;
        deg_if.deg_ready = 1'b1;
        i_EXECUTE_PE_ELU = 1'b1;
        @(negedge i_clk);
        i_stop_dec = 1'b0;
        deg_if.deg_ready = 1'b0;
        i_EXECUTE_PE_ELU = 1'b0;
        checks++;
        if ({o_busy, o_overrun, deg_if.deg_valid, got()} !== '0) begin
            errors++;
            $display("FAIL stop_clear: got %b expected 0", {o_busy, o_overrun, deg_if.deg_valid, got()});
        end
        start_run(15'h1000, 1'b0);
        do_pulses(ECC_T - 1);
        repeat (4) @(negedge i_clk);
        checks++;
        if (deg_if.deg_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_count: valid=%b busy=%b expected 0 1", deg_if.deg_valid, o_busy);
        end
        do_pulses(1);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 2 || got() !== e) begin
            errors++;
            $display("FAIL stop_rerun: got %b wait %0d expected %b wait 2", got(), cyc, e);
        end
        accept();
    endtask

    task automatic test_async_reset();
        logic [DEG_W+1:0] e;
        int cyc;
        i_v_deg_chk_bits = 15'h0400;
        do_pulses(7);
        #2 i_nRESET_KES = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_overrun, deg_if.deg_valid, got()} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0", {o_busy, o_overrun, deg_if.deg_valid, got()});
        end
        @(negedge i_clk) i_nRESET_KES = 1'b1;
        start_run(15'h0400, 1'b0);
        do_pulses(ECC_T);
        wait_valid(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 2 || got() !== e) begin
            errors++;
            $display("FAIL post_reset_run: got %b wait %0d expected %b wait 2", got(), cyc, e);
        end
        accept();
    endtask

    initial begin
        deg_if.deg_ready = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_overrun_stop();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_d_kes_elp_deg_chk
`default_nettype wire
